bram_fifo_ctrl: RTL and testbench



---
 rtl/bram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: valid/ready stream FIFO over a single-port read-first BRAM, with a
// 3-entry output skid buffer. Define BRAM_FIFO_LEVEL_EN to add the level port.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  full,
  output logic                  empty
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT0_C   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT1_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR0_C   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR1_C   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA0_C  = {DATA_WIDTH{1'b0}};

  logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic                  inflight_r;
  logic [1:0]            ob_cnt_r;
  logic [DATA_WIDTH-1:0] ob_r     [0:2];
  logic [DATA_WIDTH-1:0] ob_nxt_s [0:2];
  logic [1:0]            ob_cnt_nxt_s;
  logic [1:0]            land_idx_s;
  logic [2:0]            occ_s;
  logic                  rd_want_s, rd_pri_s, wr_go_s, rd_go_s, pop_s;

  // Arbitration decodes use registered state only, so m_ready never reaches the port.
  assign occ_s     = {1'b0, ob_cnt_r} + {2'b00, inflight_r};
  assign rd_want_s = (cnt_r != CNT0_C) && (occ_s < 3'd3);
  assign rd_pri_s  = rd_want_s && (ob_cnt_r == 2'd0) && !inflight_r;
  assign full      = (cnt_r == DEPTH_C);
  assign empty     = (cnt_r == CNT0_C);
  assign s_ready   = rsta_n && !full && !rd_pri_s;
  assign wr_go_s   = s_valid && s_ready;
  assign rd_go_s   = rd_want_s && !wr_go_s;
  assign bram_we   = wr_go_s;
  assign bram_addr = wr_go_s ? wr_ptr_r : rd_ptr_r;
  assign bram_din  = s_data;
  assign m_valid   = (ob_cnt_r != 2'd0);
  assign m_data    = ob_r[0];
  assign pop_s     = m_valid && m_ready;
  assign land_idx_s = ob_cnt_r - {1'b0, pop_s};

`ifdef BRAM_FIFO_LEVEL_EN
  assign level = {1'b0, cnt_r} + {{(ADDR_WIDTH+1){1'b0}}, inflight_r}
               + {{ADDR_WIDTH{1'b0}}, ob_cnt_r};
`endif

  // Output buffer next state: shift on pop, then land the read word behind the survivors.
  always_comb begin
    ob_nxt_s[0]  = ob_r[0];
    ob_nxt_s[1]  = ob_r[1];
    ob_nxt_s[2]  = ob_r[2];
    ob_cnt_nxt_s = ob_cnt_r;
    if (pop_s) begin
      ob_nxt_s[0] = ob_r[1];
      ob_nxt_s[1] = ob_r[2];
    end else begin
      ob_nxt_s[0] = ob_r[0];
      ob_nxt_s[1] = ob_r[1];
    end
    if (inflight_r) begin
      case (land_idx_s)
        2'd0:    ob_nxt_s[0] = bram_dout;
        2'd1:    ob_nxt_s[1] = bram_dout;
        2'd2:    ob_nxt_s[2] = bram_dout;
        default: ;
      endcase
      ob_cnt_nxt_s = land_idx_s + 2'd1;
    end else begin
      ob_cnt_nxt_s = land_idx_s;
    end
  end

  // Pointers, occupancy and in-flight flag; bram_dout is only trusted the cycle after a read.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_ptr_r   <= PTR0_C;
      rd_ptr_r   <= PTR0_C;
      cnt_r      <= CNT0_C;
      inflight_r <= 1'b0;
    end else begin
      if (wr_go_s) begin
        wr_ptr_r <= wr_ptr_r + PTR1_C;
        cnt_r    <= cnt_r + CNT1_C;
      end else if (rd_go_s) begin
        rd_ptr_r <= rd_ptr_r + PTR1_C;
        cnt_r    <= cnt_r - CNT1_C;
      end
      inflight_r <= rd_go_s;
    end
  end

  // Output skid buffer storage.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      ob_cnt_r <= 2'd0;
      for (int i = 0; i < 3; i++) ob_r[i] <= DATA0_C;
    end else begin
      ob_cnt_r <= ob_cnt_nxt_s;
      for (int i = 0; i < 3; i++) ob_r[i] <= ob_nxt_s[i];
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: table vectors plus scoreboard-checked sequences for bram_fifo_ctrl
// (ADDR_WIDTH=4) driving a behavioural read-first BRAM.
module tb_bram_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clka = 1'b0;
  logic          rsta_n = 1'b0;
  logic [DW-1:0] s_data = 16'h0000;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          full, empty;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clka(clka), .rsta_n(rsta_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .full(full), .empty(empty)
`ifdef BRAM_FIFO_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clka = ~clka;

  // Read-first single-port BRAM model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 16'hDEAD;
  always @(posedge clka) begin
    bram_dout <= mem[bram_addr];
    if (bram_we) mem[bram_addr] <= bram_din;
  end

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  int popped = 0;
  logic [DW-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accepted write, compare on output handshake
  always @(negedge clka) begin
    if (rsta_n) begin
      if (s_valid && s_ready) begin
        sb.push_back(s_data);
        accepted++;
      end
      if (m_valid && m_ready) begin
        popped++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got %0h expected no output", m_data);
        end else begin
          chk("sb_data", m_data, sb.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    logic          e_sready;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_mvalid;
    logic [DW-1:0] e_mdata;
    logic          e_empty;
  } vec_t;
  vec_t tbl [5];

  task automatic step(input logic sv, input logic [DW-1:0] d, input logic mr);
    @(posedge clka);
    #1;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    @(negedge clka);
  endtask

  initial begin
    int base, budget, pbase;
    // single word: {s_valid, data, m_ready} -> {s_ready, we, addr, m_valid, m_data, empty}
    tbl[0] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0000, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 16'h1234, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0000, 1'b1};

    // Reset state, with s_valid held high to show no write leaks through
    s_valid = 1'b1;
    repeat (2) @(posedge clka);
    @(negedge clka);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_bram_we", bram_we, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("rst_level", level, 6'd0);
`endif
    @(posedge clka);
    #1;
    s_valid = 1'b0;
    rsta_n  = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].sv, tbl[i].d, tbl[i].mr);
      chk($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].e_sready);
      chk($sformatf("tbl%0d_bram_we", i), bram_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_bram_addr", i), bram_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].e_mvalid);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
      if (tbl[i].e_mvalid) chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].e_mdata);
    end

    // Fill to full with the output blocked
    base = accepted;
    for (int i = 0; i < 40; i++) step(1'b1, 16'h0100 + 16'(accepted - base), 1'b0);
    chk("fill_accepted", accepted - base, 19);
    chk("fill_full", full, 1'b1);
    chk("fill_s_ready", s_ready, 1'b0);
    chk("fill_m_valid", m_valid, 1'b1);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("fill_level", level, 6'd19);
`endif

    // Drain at full rate: 19 words back to back
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      chk($sformatf("drain_valid%0d", i), m_valid, 1'b1);
    end
    step(1'b0, 16'h0000, 1'b1);
    chk("drain_done_valid", m_valid, 1'b0);
    chk("drain_done_empty", empty, 1'b1);
    chk("drain_sb_empty", sb.size(), 0);

    // Arbitration: read priority steals exactly one cycle from a held write
    step(1'b1, 16'hA000, 1'b0);
    chk("arb_c0_s_ready", s_ready, 1'b1);
    step(1'b1, 16'hA001, 1'b0);
    chk("arb_c1_s_ready", s_ready, 1'b0);
    chk("arb_c1_bram_we", bram_we, 1'b0);
    step(1'b1, 16'hA001, 1'b0);
    chk("arb_c2_s_ready", s_ready, 1'b1);
    chk("arb_c2_bram_we", bram_we, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b1);
    chk("arb_sb_empty", sb.size(), 0);

    // Wrap-around with random handshakes
    base = accepted;
    budget = 0;
    while ((accepted - base) < 100 && budget < 2000) begin
      step(((accepted - base) < 100) && ($urandom_range(0, 1) == 1), 16'($urandom),
           $urandom_range(0, 3) != 0);
      budget++;
    end
    chk("wrap_accepted", accepted - base, 100);
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      step(1'b0, 16'h0000, 1'b1);
      budget++;
    end
    chk("wrap_sb_empty", sb.size(), 0);
    chk("wrap_empty", empty, 1'b1);

    // Reset mid-stream with 5 words held
    base = accepted;
    budget = 0;
    while ((accepted - base) < 5 && budget < 30) begin
      step(1'b1, 16'h5000 + 16'(accepted - base), 1'b0);
      budget++;
    end
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("mid_held_valid", m_valid, 1'b1);
    @(posedge clka);
    #1;
    rsta_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_s_ready", s_ready, 1'b0);
    sb.delete();
    @(posedge clka);
    #1;
    rsta_n = 1'b1;
    pbase = popped;
    step(1'b1, 16'hBEEF, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b1);
    chk("mid_new_pops", popped - pbase, 1);
    chk("mid_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
